// File: rtl/sdr_arb_pkg.sv
// sdr_arb_pkg: shared types and constants for the SDRAM Wishbone arbiter.
//   arb_state_t : arbiter FSM states (IDLE, OWN0, OWN1, RELEASE)
//   CTI_*       : Wishbone cycle type identifiers
//   DEFAULT_AW  : default Wishbone address width
//   state_gnt   : one-hot grant vector for a given arbiter state
package sdr_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OWN0    = 2'd1,
        OWN1    = 2'd2,
        RELEASE = 2'd3
    } arb_state_t;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    localparam int unsigned DEFAULT_AW = 26;

    function automatic logic [1:0] state_gnt(input arb_state_t s);
        case (s)
            OWN0:    return 2'b01;
            OWN1:    return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/sdr_arb_rr_pick.sv
// sdr_arb_rr_pick: combinational 2-way round-robin picker.
//   req[1:0]   in  : active requests (already qualified by the caller)
//   last_owner in  : index of the requester that owned most recently
//   pick_valid out : at least one request is active
//   pick_idx   out : index of the chosen requester (valid when pick_valid)
module sdr_arb_rr_pick (
    input  logic [1:0] req,
    input  logic       last_owner,
    output logic       pick_valid,
    output logic       pick_idx
);

    always_comb begin
        pick_valid = |req;
        // On a tie the requester that did not own last wins.
        if (&req) begin
            pick_idx = ~last_owner;
        end else begin
            pick_idx = req[1];
        end
    end

endmodule

// File: rtl/sdr_wb_arbiter.sv
// sdr_wb_arbiter: two-master round-robin Wishbone arbiter in front of the
// SDRAM controller slave port. A grant is held for the whole Wishbone cycle
// (until the owner drops cyc), followed by one dead RELEASE cycle. No grant
// is issued while sdr_init_done is low.
//
// Optional feature (macro SDR_ARB_TIMEOUT_EN): stall watchdog. While owning,
// cycles with wb_stb_i=1 and wb_ack_o=0 are counted; on the TIMEOUT_CYC-th
// consecutive stalled cycle timeout_o pulses and the grant is forcibly
// released. Without the macro no counter exists and timeout_o is 0.
//
// Ports:
//   sys_clk, RESET         : clock, asynchronous active-high reset
//   sdr_init_done          : SDRAM init complete, gates new grants
//   m0_* / m1_*            : master Wishbone ports (inputs _i, outputs _o)
//   wb_*_i (out)           : muxed Wishbone request towards the controller
//   wb_ack_o, wb_dat_o (in): controller response
//   gnt_o                  : one-hot current owner, 00 when idle
//   timeout_o              : one-cycle watchdog pulse
module sdr_wb_arbiter
    import sdr_arb_pkg::*;
#(
    parameter int unsigned dw          = 32,
    parameter int unsigned AW          = DEFAULT_AW,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic            sys_clk,
    input  logic            RESET,
    input  logic            sdr_init_done,

    input  logic            m0_cyc_i,
    input  logic            m0_stb_i,
    input  logic            m0_we_i,
    input  logic [AW-1:0]   m0_addr_i,
    input  logic [dw-1:0]   m0_dat_i,
    input  logic [dw/8-1:0] m0_sel_i,
    input  logic [2:0]      m0_cti_i,
    output logic            m0_ack_o,
    output logic [dw-1:0]   m0_dat_o,

    input  logic            m1_cyc_i,
    input  logic            m1_stb_i,
    input  logic            m1_we_i,
    input  logic [AW-1:0]   m1_addr_i,
    input  logic [dw-1:0]   m1_dat_i,
    input  logic [dw/8-1:0] m1_sel_i,
    input  logic [2:0]      m1_cti_i,
    output logic            m1_ack_o,
    output logic [dw-1:0]   m1_dat_o,

    output logic            wb_cyc_i,
    output logic            wb_stb_i,
    output logic            wb_we_i,
    output logic [AW-1:0]   wb_addr_i,
    output logic [dw-1:0]   wb_dat_i,
    output logic [dw/8-1:0] wb_sel_i,
    output logic [2:0]      wb_cti_i,
    input  logic            wb_ack_o,
    input  logic [dw-1:0]   wb_dat_o,

    output logic [1:0]      gnt_o,
    output logic            timeout_o
);

    arb_state_t state_q;
    logic [1:0] gnt_q;
    logic       last_owner_q;

    logic       pick_valid;
    logic       pick_idx;
    logic       owning;
    logic       timeout_fire;

    sdr_arb_rr_pick u_pick (
        .req        ({m1_cyc_i, m0_cyc_i} & {2{sdr_init_done}}),
        .last_owner (last_owner_q),
        .pick_valid (pick_valid),
        .pick_idx   (pick_idx)
    );

    assign owning = (state_q == OWN0) || (state_q == OWN1);

`ifdef SDR_ARB_TIMEOUT_EN
    localparam int unsigned CntW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    logic [CntW-1:0] to_cnt_q;

    // Fires on the cycle the counter already holds TIMEOUT_CYC-1 stalled cycles
    // and the current cycle is stalled too.
    assign timeout_fire = owning && wb_stb_i && !wb_ack_o &&
                          (to_cnt_q == CntW'(TIMEOUT_CYC - 1));

    always_ff @(posedge sys_clk or posedge RESET) begin
        if (RESET) begin
            to_cnt_q <= '0;
        end else if (owning && wb_stb_i && !wb_ack_o && !timeout_fire &&
                     !((state_q == OWN0) && !m0_cyc_i) &&
                     !((state_q == OWN1) && !m1_cyc_i)) begin
            to_cnt_q <= to_cnt_q + 1'b1;
        end else begin
            to_cnt_q <= '0;
        end
    end
`else
    assign timeout_fire = 1'b0;
`endif

    assign timeout_o = timeout_fire;
    assign gnt_o     = gnt_q;

    // Arbiter FSM; gnt_q is registered alongside the state.
    always_ff @(posedge sys_clk or posedge RESET) begin
        if (RESET) begin
            state_q      <= IDLE;
            gnt_q        <= 2'b00;
            last_owner_q <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_valid) begin
                        state_q      <= pick_idx ? OWN1 : OWN0;
                        gnt_q        <= state_gnt(pick_idx ? OWN1 : OWN0);
                        last_owner_q <= pick_idx;
                    end
                end
                OWN0: begin
                    if (!m0_cyc_i || timeout_fire) begin
                        state_q <= RELEASE;
                        gnt_q   <= 2'b00;
                    end
                end
                OWN1: begin
                    if (!m1_cyc_i || timeout_fire) begin
                        state_q <= RELEASE;
                        gnt_q   <= 2'b00;
                    end
                end
                RELEASE: begin
                    state_q <= IDLE;
                    gnt_q   <= 2'b00;
                end
                default: begin
                    state_q <= IDLE;
                    gnt_q   <= 2'b00;
                end
            endcase
        end
    end

    // Request/response steering; everything is zero outside OWNx.
    always_comb begin
        wb_cyc_i  = 1'b0;
        wb_stb_i  = 1'b0;
        wb_we_i   = 1'b0;
        wb_addr_i = '0;
        wb_dat_i  = '0;
        wb_sel_i  = '0;
        wb_cti_i  = 3'b000;
        m0_ack_o  = 1'b0;
        m0_dat_o  = '0;
        m1_ack_o  = 1'b0;
        m1_dat_o  = '0;
        case (state_q)
            OWN0: begin
                wb_cyc_i  = m0_cyc_i;
                wb_stb_i  = m0_stb_i;
                wb_we_i   = m0_we_i;
                wb_addr_i = m0_addr_i;
                wb_dat_i  = m0_dat_i;
                wb_sel_i  = m0_sel_i;
                wb_cti_i  = m0_cti_i;
                m0_ack_o  = wb_ack_o;
                m0_dat_o  = wb_dat_o;
            end
            OWN1: begin
                wb_cyc_i  = m1_cyc_i;
                wb_stb_i  = m1_stb_i;
                wb_we_i   = m1_we_i;
                wb_addr_i = m1_addr_i;
                wb_dat_i  = m1_dat_i;
                wb_sel_i  = m1_sel_i;
                wb_cti_i  = m1_cti_i;
                m1_ack_o  = wb_ack_o;
                m1_dat_o  = wb_dat_o;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_sdr_wb_arbiter.sv
module tb_sdr_wb_arbiter;

    localparam int AW = 26;
    localparam int DW = 32;
    localparam int TO = 16;

    logic          sys_clk = 1'b0;
    logic          RESET;
    logic          sdr_init_done;
    logic          m0_cyc_i, m0_stb_i, m0_we_i;
    logic [AW-1:0] m0_addr_i;
    logic [DW-1:0] m0_dat_i;
    logic [3:0]    m0_sel_i;
    logic [2:0]    m0_cti_i;
    logic          m0_ack_o;
    logic [DW-1:0] m0_dat_o;
    logic          m1_cyc_i, m1_stb_i, m1_we_i;
    logic [AW-1:0] m1_addr_i;
    logic [DW-1:0] m1_dat_i;
    logic [3:0]    m1_sel_i;
    logic [2:0]    m1_cti_i;
    logic          m1_ack_o;
    logic [DW-1:0] m1_dat_o;
    logic          wb_cyc_i, wb_stb_i, wb_we_i;
    logic [AW-1:0] wb_addr_i;
    logic [DW-1:0] wb_dat_i;
    logic [3:0]    wb_sel_i;
    logic [2:0]    wb_cti_i;
    logic          wb_ack_o;
    logic [DW-1:0] wb_dat_o;
    logic [1:0]    gnt_o;
    logic          timeout_o;

    // Bench-side controller: acks a strobed cycle when slave_ack_en is set.
    logic          slave_ack_en;
    logic [DW-1:0] slave_dat;
    assign wb_ack_o = wb_cyc_i & wb_stb_i & slave_ack_en;
    assign wb_dat_o = slave_dat;

    int errors = 0;
    int checks = 0;

    sdr_wb_arbiter #(.dw(DW), .AW(AW), .TIMEOUT_CYC(TO)) dut (
        .sys_clk(sys_clk), .RESET(RESET), .sdr_init_done(sdr_init_done),
        .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
        .m0_addr_i(m0_addr_i), .m0_dat_i(m0_dat_i), .m0_sel_i(m0_sel_i),
        .m0_cti_i(m0_cti_i), .m0_ack_o(m0_ack_o), .m0_dat_o(m0_dat_o),
        .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
        .m1_addr_i(m1_addr_i), .m1_dat_i(m1_dat_i), .m1_sel_i(m1_sel_i),
        .m1_cti_i(m1_cti_i), .m1_ack_o(m1_ack_o), .m1_dat_o(m1_dat_o),
        .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
        .wb_addr_i(wb_addr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i),
        .wb_cti_i(wb_cti_i), .wb_ack_o(wb_ack_o), .wb_dat_o(wb_dat_o),
        .gnt_o(gnt_o), .timeout_o(timeout_o)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    // Behavioural model: who owns the port, whether a dead cycle is pending,
    // who owned last, and how many consecutive stalled cycles have elapsed.
    int m_owner = 0;   // 0 none, 1 master 0, 2 master 1
    bit m_rel   = 0;
    int m_last  = 1;
    int m_cnt   = 0;

    always @(negedge sys_clk) begin : scoreboard
        logic [1:0]    e_gnt;
        logic          e_cyc, e_stb, e_we, e_ack, e_to;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_dat, e_m0_dat, e_m1_dat;
        logic [3:0]    e_sel;
        logic [2:0]    e_cti;
        logic          e_m0_ack, e_m1_ack;
        int            w;
        e_gnt = 2'b00; e_cyc = 0; e_stb = 0; e_we = 0; e_addr = '0; e_dat = '0;
        e_sel = '0; e_cti = '0; e_to = 0;
        e_m0_ack = 0; e_m1_ack = 0; e_m0_dat = '0; e_m1_dat = '0;
        if (!RESET && m_owner == 1) begin
            e_gnt = 2'b01; e_cyc = m0_cyc_i; e_stb = m0_stb_i; e_we = m0_we_i;
            e_addr = m0_addr_i; e_dat = m0_dat_i; e_sel = m0_sel_i; e_cti = m0_cti_i;
        end else if (!RESET && m_owner == 2) begin
            e_gnt = 2'b10; e_cyc = m1_cyc_i; e_stb = m1_stb_i; e_we = m1_we_i;
            e_addr = m1_addr_i; e_dat = m1_dat_i; e_sel = m1_sel_i; e_cti = m1_cti_i;
        end
        e_ack = e_cyc & e_stb & slave_ack_en;
        if (!RESET && m_owner == 1) begin e_m0_ack = e_ack; e_m0_dat = slave_dat; end
        if (!RESET && m_owner == 2) begin e_m1_ack = e_ack; e_m1_dat = slave_dat; end
`ifdef SDR_ARB_TIMEOUT_EN
        e_to = !RESET && m_owner != 0 && e_stb && !e_ack && (m_cnt == TO - 1);
`endif
        chk("gnt", 64'(gnt_o), 64'(e_gnt));
        chk("wb_ctl", 64'({wb_cyc_i, wb_stb_i, wb_we_i}), 64'({e_cyc, e_stb, e_we}));
        chk("wb_addr", 64'(wb_addr_i), 64'(e_addr));
        chk("wb_dat", 64'(wb_dat_i), 64'(e_dat));
        chk("wb_sel_cti", 64'({wb_sel_i, wb_cti_i}), 64'({e_sel, e_cti}));
        chk("m_ack", 64'({m0_ack_o, m1_ack_o}), 64'({e_m0_ack, e_m1_ack}));
        chk("m0_dat", 64'(m0_dat_o), 64'(e_m0_dat));
        chk("m1_dat", 64'(m1_dat_o), 64'(e_m1_dat));
        chk("timeout", 64'(timeout_o), 64'(e_to));
        // Advance the model to what the coming rising edge produces.
        if (RESET) begin
            m_owner = 0; m_rel = 0; m_last = 1; m_cnt = 0;
        end else if (m_rel) begin
            m_rel = 0;
        end else if (m_owner == 0) begin
            w = -1;
            if (sdr_init_done && m0_cyc_i && m1_cyc_i) w = (m_last == 1) ? 0 : 1;
            else if (sdr_init_done && m0_cyc_i) w = 0;
            else if (sdr_init_done && m1_cyc_i) w = 1;
            if (w >= 0) begin m_owner = w + 1; m_last = w; m_cnt = 0; end
        end else if (!e_cyc || e_to) begin
            m_owner = 0; m_rel = 1; m_cnt = 0;
        end else if (e_stb && !e_ack) begin
            m_cnt++;
        end else begin
            m_cnt = 0;
        end
    end

    initial begin
        RESET = 1; sdr_init_done = 0; slave_ack_en = 1; slave_dat = '0;
        m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0; m0_addr_i = '0; m0_dat_i = '0;
        m0_sel_i = '0; m0_cti_i = '0;
        m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0; m1_addr_i = '0; m1_dat_i = '0;
        m1_sel_i = '0; m1_cti_i = '0;

        // Reset, then init gate.
        repeat (3) tick();
        RESET = 0; m0_cyc_i = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge sys_clk);
            chk("init_gate_gnt", 64'(gnt_o), 64'd0);
            chk("init_gate_cyc", 64'(wb_cyc_i), 64'd0);
            tick();
        end
        sdr_init_done = 1;
        tick();
        @(negedge sys_clk);
        chk("init_grant", 64'(gnt_o), 64'd1);
        tick();
        m0_cyc_i = 0;
        repeat (2) tick();

        // Tie break after reset.
        RESET = 1;
        repeat (3) tick();
        RESET = 0; m0_cyc_i = 1; m1_cyc_i = 1;
        tick();
        @(negedge sys_clk);
        chk("tie_first", 64'(gnt_o), 64'd1);
        tick();
        m0_cyc_i = 0;
        tick();
        @(negedge sys_clk);
        chk("tie_release_gnt", 64'(gnt_o), 64'd0);
        chk("tie_release_cyc", 64'(wb_cyc_i), 64'd0);
        tick();
        @(negedge sys_clk);
        chk("tie_idle", 64'(gnt_o), 64'd0);
        tick();
        @(negedge sys_clk);
        chk("tie_second", 64'(gnt_o), 64'd2);
        tick();
        m1_cyc_i = 0;
        tick();
        m0_cyc_i = 1; m1_cyc_i = 1;
        repeat (2) tick();
        @(negedge sys_clk);
        chk("tie_next", 64'(gnt_o), 64'd1);
        tick();
        m0_cyc_i = 0; m1_cyc_i = 0;
        repeat (3) tick();

        // Burst integrity: m0 4-beat INCR write while m1 waits.
        begin
            int acks;
            acks = 0;
            m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 1; m0_sel_i = 4'hF;
            m0_addr_i = 26'h0000100; m0_cti_i = 3'b010; m0_dat_i = 32'h11110000;
            tick();
            m1_cyc_i = 1;
            for (int b = 0; b < 4; b++) begin
                m0_addr_i = 26'h0000100 + 26'(4 * b);
                m0_cti_i  = (b == 3) ? 3'b111 : 3'b010;
                m0_dat_i  = 32'h11110000 + 32'(b);
                @(negedge sys_clk);
                chk("burst_wb_addr", 64'(wb_addr_i), 64'(26'h0000100 + 26'(4 * b)));
                chk("burst_m1_ack", 64'(m1_ack_o), 64'd0);
                if (m0_ack_o) acks++;
                tick();
            end
            chk("burst_acks", 64'(acks), 64'd4);
        end
        m0_cyc_i = 0; m0_stb_i = 0;
        @(negedge sys_clk);
        chk("burst_drop_cyc", 64'(wb_cyc_i), 64'd0);
        tick();
        @(negedge sys_clk);
        chk("burst_release", 64'(gnt_o), 64'd0);
        tick();
        @(negedge sys_clk);
        chk("burst_idle", 64'(gnt_o), 64'd0);
        tick();
        @(negedge sys_clk);
        chk("burst_m1_gnt", 64'(gnt_o), 64'd2);

        // Read data routing to m1.
        tick();
        m1_stb_i = 1; m1_we_i = 0; m1_addr_i = 26'h3FFFFFC; m1_cti_i = 3'b000;
        slave_dat = 32'hDEADBEEF;
        @(negedge sys_clk);
        chk("read_m1_dat", 64'(m1_dat_o), 64'h00000000DEADBEEF);
        chk("read_m0_dat", 64'(m0_dat_o), 64'd0);
        chk("read_m1_ack", 64'(m1_ack_o), 64'd1);
        chk("read_addr", 64'(wb_addr_i), 64'h3FFFFFC);
        tick();
        m1_cyc_i = 0; m1_stb_i = 0;
        repeat (3) tick();

        // Reset in the middle of an m1 burst.
        m1_cyc_i = 1; m1_stb_i = 1; m1_we_i = 1; m1_cti_i = 3'b010; m1_addr_i = 26'h200;
        tick();
        @(negedge sys_clk);
        chk("mid_gnt", 64'(gnt_o), 64'd2);
        tick();
        m1_addr_i = 26'h204;
        #1 RESET = 1;
        #1;
        chk("mid_rst_gnt", 64'(gnt_o), 64'd0);
        chk("mid_rst_ctl", 64'({wb_cyc_i, wb_stb_i, wb_we_i}), 64'd0);
        chk("mid_rst_addr", 64'(wb_addr_i), 64'd0);
        chk("mid_rst_m1", 64'({m1_ack_o, m1_dat_o}), 64'd0);
        m0_cyc_i = 1;
        repeat (2) tick();
        RESET = 0;
        tick();
        @(negedge sys_clk);
        chk("mid_after_tie", 64'(gnt_o), 64'd1);
        tick();
        m0_cyc_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
        repeat (3) tick();

`ifdef SDR_ARB_TIMEOUT_EN
        // Watchdog: m0 strobes, controller never acks.
        slave_ack_en = 0;
        m0_cyc_i = 1; m0_stb_i = 1;
        tick();
        for (int k = 1; k <= TO; k++) begin
            @(negedge sys_clk);
            chk("wdog_pulse", 64'(timeout_o), 64'(k == TO));
            tick();
        end
        @(negedge sys_clk);
        chk("wdog_cyc_drop", 64'(wb_cyc_i), 64'd0);
        chk("wdog_gnt_drop", 64'(gnt_o), 64'd0);
        m0_cyc_i = 0; m0_stb_i = 0; slave_ack_en = 1;
        repeat (3) tick();
`endif

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 5) == 0) m0_cyc_i = ~m0_cyc_i;
            if ($urandom_range(0, 5) == 0) m1_cyc_i = ~m1_cyc_i;
            if ($urandom_range(0, 39) == 0) sdr_init_done = ~sdr_init_done;
            RESET = ($urandom_range(0, 399) == 0);
            m0_stb_i = 1'($urandom); m0_we_i = 1'($urandom);
            m0_addr_i = 26'($urandom); m0_dat_i = $urandom;
            m0_sel_i = 4'($urandom); m0_cti_i = 3'($urandom);
            m1_stb_i = 1'($urandom); m1_we_i = 1'($urandom);
            m1_addr_i = 26'($urandom); m1_dat_i = $urandom;
            m1_sel_i = 4'($urandom); m1_cti_i = 3'($urandom);
            slave_ack_en = ($urandom_range(0, 3) != 0);
            slave_dat = $urandom;
            tick();
        end
        RESET = 0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sdr_wb_arbiter.md
Name: sdr_wb_arbiter

Overview:
- Two-master Wishbone arbiter that shares the single Wishbone slave port of the SDRAM controller between requesters, e.g. the testbench driver and a refresh/background traffic agent.
- Sits between the masters and the controller's wb_* port.
- Round-robin grant, held for the whole Wishbone cycle so bursts are never split.
- Grants only after sdr_init_done.

Parameters:
- dw, 32, Wishbone data width; sel width is dw/8.
- AW, 26, Wishbone address width.
- TIMEOUT_CYC, 1024, watchdog limit in sys_clk cycles; used only with SDR_ARB_TIMEOUT_EN.

Ports:
- sys_clk  in  1  system clock; all logic on rising edge.
- RESET  in  1  asynchronous, active-high reset.
- sdr_init_done  in  1  SDRAM init complete; no grant while low.
- m0_cyc_i, m0_stb_i, m0_we_i  in  1 each  master 0 Wishbone controls.
- m0_addr_i  in  AW  master 0 address.
- m0_dat_i  in  dw  master 0 write data.
- m0_sel_i  in  dw/8  master 0 byte enables.
- m0_cti_i  in  3  master 0 cycle type.
- m0_ack_o  out  1  master 0 acknowledge.
- m0_dat_o  out  dw  master 0 read data.
- m1_*  same set and widths as m0_*  master 1.
- wb_cyc_i, wb_stb_i, wb_we_i  out  1 each  to controller.
- wb_addr_i  out  AW  to controller.
- wb_dat_i  out  dw  to controller.
- wb_sel_i  out  dw/8  to controller.
- wb_cti_i  out  3  to controller.
- wb_ack_o  in  1  from controller.
- wb_dat_o  in  dw  from controller.
- gnt_o  out  2  one-hot current owner; 00 when idle.
- timeout_o  out  1  one-cycle watchdog pulse.

Behaviour:
- FSM states: IDLE, OWN0, OWN1, RELEASE. State is registered.
- IDLE: requests are m0_cyc_i and m1_cyc_i, each qualified by sdr_init_done.
  - Single request: go to the matching OWNx.
  - Both requesting: grant the master that did not own last. last_owner resets to 1, so m0 wins the first tie.
  - Grant latency: cyc seen at edge N gives gnt_o and wb_cyc_i at N+1.
- OWNx:
  - wb_* outputs are a combinational mux of master x inputs.
  - m{x}_ack_o = wb_ack_o and m{x}_dat_o = wb_dat_o.
  - The non-owner sees ack 0 and dat_o 0.
  - last_owner is updated to x on entry.
- Exit OWNx to RELEASE on the first edge where mx_cyc_i = 0.
  - The cti value does not release the grant; burst end (cti 3'b111) is the master's responsibility, and the master then drops cyc.
- RELEASE: one dead cycle with all wb_* controls 0, then IDLE.
  - Guarantees the controller sees cyc low between owners.
- Controls in IDLE/RELEASE: wb_cyc_i, wb_stb_i, wb_we_i = 0. Addr, data, sel and cti = 0.
- Non-owner requests: held off indefinitely; a master must keep cyc high while waiting.
- sdr_init_done falls while owning: the current grant continues until cyc drops. No new grant is issued while it is low.
- Reset, including mid-transfer: state = IDLE, gnt_o = 00, every output 0, last_owner = 1, watchdog = 0.
  - Asynchronous assert, synchronous release.
- Simultaneous events: owner drops cyc while the other raises it in the same cycle gives RELEASE, then IDLE, then grant.
  - Minimum gap between owners' cyc is 2 cycles.

Optional Feature:
- Macro: SDR_ARB_TIMEOUT_EN.
- Enabled: a counter increments each cycle in OWNx while wb_stb_i = 1 and wb_ack_o = 0, and clears on ack or on leaving OWNx.
  - At TIMEOUT_CYC - 1, timeout_o pulses for 1 cycle.
  - The FSM forces RELEASE, dropping wb_cyc_i and wb_stb_i regardless of the master.
  - The owner receives no ack; the master must drop cyc, which the next IDLE arbitration observes.
- Disabled: no counter is built and timeout_o is tied to 0.

Decomposition:
- Package sdr_arb_pkg:
  - arb_state_t enum {IDLE, OWN0, OWN1, RELEASE}.
  - CTI_CLASSIC = 3'b000, CTI_INCR = 3'b010, CTI_EOB = 3'b111.
  - Default AW = 26.
- Sub-module sdr_arb_rr_pick: combinational 2-way round-robin picker.
  - Inputs: req[1:0], last_owner.
  - Outputs: pick_valid, pick_idx.
  - Reused later for wider arbiters.

Test Plan:
- Reset then init gate: RESET=1 for 3 cycles; m0_cyc_i=1 with sdr_init_done=0 for 10 cycles. Required: gnt_o=00 and wb_cyc_i=0 throughout. After sdr_init_done rises, gnt_o=01 one cycle later.
- Tie break: m0 and m1 raise cyc on the same edge after reset. Required: m0 is granted first. After m0 drops cyc, RELEASE for 1 cycle, then gnt_o=10. The next tie goes to m0.
- Burst integrity: m0 does a 4-beat INCR write at 0x0000100 (cti 010,010,010,111) while m1 requests. Required: all 4 acks reach only m0, m1_ack_o stays 0, and m1 is granted 2 cycles after m0 cyc falls.
- Read data routing: m1 reads 0x3FFFFFC, controller returns 0xDEADBEEF. Required: m1_dat_o = 0xDEADBEEF and m0_dat_o = 0.
- Reset mid-burst: assert RESET during the 2nd beat of an m1 burst. Required: all outputs 0 immediately (asynchronous). After release, m0 wins the next tie.
- Watchdog (SDR_ARB_TIMEOUT_EN, TIMEOUT_CYC=16): m0 strobes and the controller never acks. Required: timeout_o pulses on the 16th stalled cycle, and wb_cyc_i=0 on the next cycle.
